// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: function codes
// decoded by the execute stage and the FSM state encoding.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // Value of the iteration counter during the final quotient-bit cycle
  localparam logic [4:0] DIV_LAST_COUNT = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  // True for every function code owned by the HI/LO unit
  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    case (funct)
      FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// step, quotient shifts in where the dividend shifts out.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [4:0]  count;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  // Trial subtraction; bit 32 of diff is the borrow that rejects the step
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dsr_q};
  end

  // Load operands on accept, then shift/subtract once per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      count <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      count <= '0;
    end else if (step) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= rem_shift[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      count <= count + 5'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = step && (count == DIV_LAST_COUNT);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle-busy multiplier, 32-step
// restoring divider with a sign-fix cycle, and MTHI/MTLO/MFHI/MFLO access.
module hilo_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct_execute,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic [31:0] hilo,
  output logic        busy,
  output logic        stall
);

  muldiv_state_t state, state_next;

  logic [31:0] hi, lo;
  logic [31:0] op_a, op_b;
  logic        op_signed;
  logic        accept, is_mult, is_div, signed_op;
  logic [31:0] mag_a, mag_b;
  logic        div_load, div_step, div_last;
  logic [31:0] div_quotient, div_remainder;
  logic [63:0] product;
  logic [31:0] fix_hi, fix_lo;

  // Decode the incoming op and form divider magnitudes straight from the bus
  always_comb begin
    accept    = start && (state == ST_IDLE) && !flush;
    is_mult   = (funct_execute == FUNCT_MULT) || (funct_execute == FUNCT_MULTU);
    is_div    = (funct_execute == FUNCT_DIV)  || (funct_execute == FUNCT_DIVU);
    signed_op = (funct_execute == FUNCT_MULT) || (funct_execute == FUNCT_DIV);
    mag_a     = (signed_op && src_a[31]) ? -src_a : src_a;
    mag_b     = (signed_op && src_b[31]) ? -src_b : src_b;
    div_load  = accept && is_div;
    div_step  = (state == ST_DIV);
  end

  div_iter u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .last      (div_last)
  );

  // Latch operands on accept so later bus changes cannot disturb the op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
    end else if (accept && (is_mult || is_div)) begin
      op_a      <= src_a;
      op_b      <= src_b;
      op_signed <= signed_op;
    end
  end

  // Sign-extended 64x64 product truncated to 64 bits covers both signednesses;
  // the fix-up restores signs and handles divide by zero
  always_comb begin
    product = {{32{op_signed && op_a[31]}}, op_a} * {{32{op_signed && op_b[31]}}, op_b};
    fix_lo  = (op_signed && (op_a[31] ^ op_b[31])) ? -div_quotient : div_quotient;
    fix_hi  = (op_signed && op_a[31]) ? -div_remainder : div_remainder;
    if (op_b == 32'd0) begin
      fix_lo = 32'hFFFF_FFFF;
      fix_hi = op_a;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus busy/stall/read-port outputs; flush overrides all
  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    stall      = start && busy && is_muldiv_funct(funct_execute);
    hilo       = '0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mult)     state_next = ST_MUL;
        else if (accept && is_div) state_next = ST_DIV;
      end
      ST_MUL:  state_next = ST_IDLE;
      ST_DIV:  if (div_last) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
    if (funct_execute == FUNCT_MFHI)      hilo = hi;
    else if (funct_execute == FUNCT_MFLO) hilo = lo;
  end

  // HI/LO architectural registers; a flush suppresses every write that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      if (accept && (funct_execute == FUNCT_MTHI)) hi <= src_a;
      if (accept && (funct_execute == FUNCT_MTLO)) lo <= src_a;
      if (state == ST_MUL) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end
      if (state == ST_FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

endmodule
